// File: rtl/circle_draw_pkg.sv
// ============================================================================
// Module  : circle_draw_pkg
// Purpose : Shared types and constants for the circle-drawing controller:
//           controller state encoding, one-hot coordinate-mux select codes,
//           the octant select pair and the full registered output bundle,
//           plus the Moore output decode used by the controller.
// Ports   : none (package)
// Config  : CIRCLE_DRAW_CTRL_SKIP_CLEAR_EN - when defined, the screen-clear
//           states are not decoded (the controller goes straight to the
//           circle loop).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package circle_draw_pkg;

  localparam int SEL_WIDTH = 5;

  // X mux: CNT = x counter, PA = cx+ox, MA = cx-ox, PB = cx+oy, MB = cx-oy
  // Y mux: CNT = y counter, PA = cy+oy, MA = cy-oy, PB = cy+ox, MB = cy-ox
  localparam logic [SEL_WIDTH-1:0] SEL_NONE = 5'b00000;
  localparam logic [SEL_WIDTH-1:0] SEL_CNT  = 5'b00001;
  localparam logic [SEL_WIDTH-1:0] SEL_PA   = 5'b00010;
  localparam logic [SEL_WIDTH-1:0] SEL_MA   = 5'b00100;
  localparam logic [SEL_WIDTH-1:0] SEL_PB   = 5'b01000;
  localparam logic [SEL_WIDTH-1:0] SEL_MB   = 5'b10000;

  localparam logic [2:0] OCT_LAST = 3'd7;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CLR_INIT  = 4'd1,
    CLR_COL   = 4'd2,
    CLR_NEXT  = 4'd3,
    CIRC_INIT = 4'd4,
    CHECK     = 4'd5,
    OCT       = 4'd6,
    STEP      = 4'd7,
    DONE      = 4'd8
  } ctrl_state_t;

  typedef struct packed {
    logic [SEL_WIDTH-1:0] selx;
    logic [SEL_WIDTH-1:0] sely;
  } oct_sel_t;

  typedef struct packed {
    logic     initx;
    logic     inity;
    logic     initc;
    logic     loadx;
    logic     loady;
    logic     loadc;
    logic     flagc;
    logic     plot;
    logic     done;
    oct_sel_t sel;
  } ctrl_out_t;

  // Moore output decode for a given state; oct_sel is only used in OCT.
  function automatic ctrl_out_t decode_outputs(input ctrl_state_t st,
                                               input oct_sel_t    oct_sel);
    ctrl_out_t o;
    o = '0;
    case (st)
`ifndef CIRCLE_DRAW_CTRL_SKIP_CLEAR_EN
      CLR_INIT: begin
        o.initx = 1'b1;
        o.inity = 1'b1;
        o.loadx = 1'b1;
        o.loady = 1'b1;
      end
      CLR_COL: begin
        o.plot     = 1'b1;
        o.loady    = 1'b1;
        o.sel.selx = SEL_CNT;
        o.sel.sely = SEL_CNT;
      end
      CLR_NEXT: begin
        // Advance to the next column and rewind the row counter.
        o.loadx    = 1'b1;
        o.inity    = 1'b1;
        o.loady    = 1'b1;
        o.sel.selx = SEL_CNT;
        o.sel.sely = SEL_CNT;
      end
`endif
      CIRC_INIT: begin
        o.initc = 1'b1;
        o.initx = 1'b1;
        o.inity = 1'b1;
        o.loadx = 1'b1;
        o.loady = 1'b1;
        o.flagc = 1'b1;
      end
      CHECK: o.flagc = 1'b1;
      OCT: begin
        o.plot  = 1'b1;
        o.flagc = 1'b1;
        o.sel   = oct_sel;
      end
      STEP: begin
        o.loadc = 1'b1;
        o.flagc = 1'b1;
      end
      DONE:    o.done = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/circle_octant_lut.sv
// ============================================================================
// Module  : circle_octant_lut
// Purpose : Combinational octant index -> {selx, sely} table. Maps each of
//           the eight symmetric circle points to its coordinate-mux selects.
// Ports   : oct_i [2:0]  octant index 0..7
//           sel_o        {selx, sely} one-hot select pair
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module circle_octant_lut
  import circle_draw_pkg::*;
(
  input  logic [2:0] oct_i,
  output oct_sel_t   sel_o
);

  always_comb begin
    sel_o = '0;
    case (oct_i)
      3'd0: sel_o = '{selx: SEL_PA, sely: SEL_PA};  // (cx+ox, cy+oy)
      3'd1: sel_o = '{selx: SEL_PB, sely: SEL_PB};  // (cx+oy, cy+ox)
      3'd2: sel_o = '{selx: SEL_MA, sely: SEL_PA};  // (cx-ox, cy+oy)
      3'd3: sel_o = '{selx: SEL_MB, sely: SEL_PB};  // (cx-oy, cy+ox)
      3'd4: sel_o = '{selx: SEL_MA, sely: SEL_MA};  // (cx-ox, cy-oy)
      3'd5: sel_o = '{selx: SEL_MB, sely: SEL_MB};  // (cx-oy, cy-ox)
      3'd6: sel_o = '{selx: SEL_PA, sely: SEL_MA};  // (cx+ox, cy-oy)
      3'd7: sel_o = '{selx: SEL_PB, sely: SEL_MB};  // (cx+oy, cy-ox)
      default: sel_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/circle_draw_ctrl.sv
// ============================================================================
// Module  : circle_draw_ctrl
// Purpose : Control FSM for the circle datapath. Clears the 160x120 screen
//           with a column-major sweep, then runs the Bresenham loop plotting
//           eight octant points per step.
// Ports   : clk, resetn (sync, active-low), start (level request)
//           xdone/ydone/cdone            datapath status flags
//           initx/inity/initc            datapath initialise strobes
//           loadx/loady/loadc            datapath load/step strobes
//           flagc                        1 = circle drawing, 0 = clear
//           selx/sely [SEL_W-1:0]        one-hot coordinate-mux selects
//           plot                         VGA write strobe
//           done                         drawing complete
// Config  : CIRCLE_DRAW_CTRL_SKIP_CLEAR_EN - when defined, start goes
//           straight to CIRC_INIT and the clear states are not built.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module circle_draw_ctrl
  import circle_draw_pkg::*;
#(
  parameter int SEL_W = SEL_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             xdone,
  input  logic             ydone,
  input  logic             cdone,
  output logic             initx,
  output logic             inity,
  output logic             initc,
  output logic             loadx,
  output logic             loady,
  output logic             loadc,
  output logic             flagc,
  output logic [SEL_W-1:0] selx,
  output logic [SEL_W-1:0] sely,
  output logic             plot,
  output logic             done
);

  ctrl_state_t state_q, state_d;
  logic [2:0]  oct_q, oct_d;
  ctrl_out_t   out_q, out_d;
  oct_sel_t    lut_sel;

`ifdef CIRCLE_DRAW_CTRL_SKIP_CLEAR_EN
  // Clear-phase flags have no consumer in this build.
  logic w_unused_flags;
  assign w_unused_flags = xdone ^ ydone;
`endif

  // The table is looked up on the next octant index so that the registered
  // selects line up with the state they belong to.
  circle_octant_lut u_octant_lut (
    .oct_i (oct_d),
    .sel_o (lut_sel)
  );

  always_comb begin
    state_d = state_q;
    oct_d   = oct_q;
    case (state_q)
      IDLE: begin
        oct_d = 3'd0;
`ifdef CIRCLE_DRAW_CTRL_SKIP_CLEAR_EN
        if (start) state_d = CIRC_INIT;
`else
        if (start) state_d = CLR_INIT;
`endif
      end
`ifndef CIRCLE_DRAW_CTRL_SKIP_CLEAR_EN
      CLR_INIT: state_d = CLR_COL;
      CLR_COL: begin
        if (ydone && xdone)  state_d = CIRC_INIT;
        else if (ydone)      state_d = CLR_NEXT;
      end
      CLR_NEXT: state_d = CLR_COL;
`endif
      CIRC_INIT: state_d = CHECK;
      CHECK: begin
        oct_d = 3'd0;
        if (cdone) state_d = DONE;
        else       state_d = OCT;
      end
      OCT: begin
        oct_d = oct_q + 3'd1;  // wraps to 0 after the last octant
        if (oct_q == OCT_LAST) state_d = STEP;
      end
      STEP: state_d = CHECK;
      DONE: begin
        // A held start must be released before another run can begin.
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_d = decode_outputs(state_d, lut_sel);
  end

  // Outputs are registered from the next-state decode, so they always
  // reflect the current registered state without a combinational path.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      oct_q   <= 3'd0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      oct_q   <= oct_d;
      out_q   <= out_d;
    end
  end

  assign initx = out_q.initx;
  assign inity = out_q.inity;
  assign initc = out_q.initc;
  assign loadx = out_q.loadx;
  assign loady = out_q.loady;
  assign loadc = out_q.loadc;
  assign flagc = out_q.flagc;
  assign plot  = out_q.plot;
  assign done  = out_q.done;
  assign selx  = SEL_W'(out_q.sel.selx);
  assign sely  = SEL_W'(out_q.sel.sely);

endmodule

`default_nettype wire
